// File: rtl/iob_eth_dma_rd.sv
// TX DMA reader: fetches a frame over AXI4 read bursts and writes it byte-by-byte into the TX buffer.
// Optional feature macro IOB_ETH_DMA_RD_ERR_EN: flag non-OKAY read responses on dma_error.
module iob_eth_dma_rd #(
  parameter int AXI_ADDR_W = 32,
  parameter int DMA_DATA_W = 32,
  parameter int BUF_ADDR_W = 11,
  parameter int BURST_MAX  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_ADDR_W-1:0] dma_addr,
  input  logic [BUF_ADDR_W-1:0] dma_start_index,
  input  logic [BUF_ADDR_W-1:0] dma_end_index,
  input  logic                  dma_run,
  output logic                  dma_ready,
  output logic                  dma_error,
  output logic [BUF_ADDR_W-1:0] out_addr,
  output logic [7:0]            out_data,
  output logic                  out_wr,
  output logic                  m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [1:0]            m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rid,
  input  logic [DMA_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] UNPACK = 2'd3;
  localparam logic [31:0] BURST_LIM = 32'(BURST_MAX);

  logic [1:0]            state_reg;
  logic [AXI_ADDR_W-1:0] addr_reg;
  logic [BUF_ADDR_W-1:0] bytes_reg;
  logic [BUF_ADDR_W-1:0] ptr_reg;
  logic [DMA_DATA_W-1:0] data_reg;
  logic [1:0]            idx_reg;
  logic [1:0]            last_idx_reg;
  logic                  rlast_reg;

  logic [31:0] rem_words;
  logic [31:0] bound_words;
  logic [31:0] burst_words;
  logic        run_ok;
  logic        beat_done;
  logic        frame_done;

  // Bursts never cross a 4 KB page and never exceed the remaining frame.
  assign rem_words   = (32'(bytes_reg) + 32'd3) >> 2;
  assign bound_words = 32'd1024 - 32'(addr_reg[11:2]);

  always_comb begin
    burst_words = rem_words;
    if (burst_words > BURST_LIM)   burst_words = BURST_LIM;
    if (burst_words > bound_words) burst_words = bound_words;
  end

  assign run_ok     = dma_run && (state_reg == IDLE) && (dma_end_index > dma_start_index);
  assign beat_done  = (state_reg == UNPACK) && (idx_reg == last_idx_reg);
  assign frame_done = beat_done && rlast_reg && (bytes_reg == '0);

  assign dma_ready     = (state_reg == IDLE) || frame_done;
  assign out_wr        = (state_reg == UNPACK);
  assign out_addr      = ptr_reg;
  assign out_data      = 8'(data_reg >> {idx_reg, 3'b000});

  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = 8'(burst_words - 32'd1);
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = (state_reg == ADDR);
  assign m_axi_rready  = (state_reg == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      bytes_reg    <= '0;
      ptr_reg      <= '0;
      data_reg     <= '0;
      idx_reg      <= '0;
      last_idx_reg <= '0;
      rlast_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run_ok) begin
            addr_reg  <= dma_addr;
            bytes_reg <= dma_end_index - dma_start_index;
            ptr_reg   <= dma_start_index;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) state_reg <= DATA;
        end
        DATA: begin
          if (m_axi_rvalid) begin
            data_reg  <= m_axi_rdata;
            addr_reg  <= addr_reg + AXI_ADDR_W'(4);
            rlast_reg <= m_axi_rlast;
            idx_reg   <= '0;
            // A short final beat writes only the bytes still owed to the frame.
            if (bytes_reg >= BUF_ADDR_W'(4)) begin
              last_idx_reg <= 2'd3;
              bytes_reg    <= bytes_reg - BUF_ADDR_W'(4);
            end else begin
              last_idx_reg <= 2'(bytes_reg - BUF_ADDR_W'(1));
              bytes_reg    <= '0;
            end
            state_reg <= UNPACK;
          end
        end
        default: begin
          ptr_reg <= ptr_reg + BUF_ADDR_W'(1);
          idx_reg <= idx_reg + 2'd1;
          if (beat_done) begin
            if (!rlast_reg)             state_reg <= DATA;
            else if (bytes_reg == '0)   state_reg <= IDLE;
            else                        state_reg <= ADDR;
          end
        end
      endcase
    end
  end

`ifdef IOB_ETH_DMA_RD_ERR_EN
  logic error_reg;
  logic unused_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      error_reg <= 1'b0;
    end else if ((state_reg == IDLE) && dma_run) begin
      error_reg <= 1'b0;
    end else if ((state_reg == DATA) && m_axi_rvalid && (m_axi_rresp != 2'b00)) begin
      error_reg <= 1'b1;
    end
  end

  assign dma_error = error_reg;
  assign unused_in = m_axi_rid;
`else
  logic unused_in;

  assign dma_error = 1'b0;
  assign unused_in = ^{m_axi_rid, m_axi_rresp};
`endif

endmodule

// File: tb/tb_iob_eth_dma_rd.sv
// Self-checking bench for iob_eth_dma_rd: randomized AXI read slave with stalls and a byte-level frame model.
module tb_iob_eth_dma_rd;

  localparam int BMAX = 16;
`ifdef IOB_ETH_DMA_RD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dma_addr;
  logic [10:0] dma_start_index;
  logic [10:0] dma_end_index;
  logic        dma_run;
  logic        dma_ready;
  logic        dma_error;
  logic [10:0] out_addr;
  logic [7:0]  out_data;
  logic        out_wr;
  logic        m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [1:0]  m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic        m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  iob_eth_dma_rd #(
    .AXI_ADDR_W(32), .DMA_DATA_W(32), .BUF_ADDR_W(11), .BURST_MAX(BMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .dma_addr(dma_addr), .dma_start_index(dma_start_index), .dma_end_index(dma_end_index),
    .dma_run(dma_run), .dma_ready(dma_ready), .dma_error(dma_error),
    .out_addr(out_addr), .out_data(out_data), .out_wr(out_wr),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents: byte at address a is a[7:0] ^ pat
  logic [7:0] pat = 8'h00;
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ pat;
  endfunction

  // Observed activity
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [10:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic        wr_ready_q[$];
  int          arvalid_cycles;
  int          notready_cycles;

  // Expected activity (model)
  logic [10:0] exp_wa[$];
  logic [7:0]  exp_wd[$];
  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];

  bit stall_en   = 1'b0;
  int err_beat   = -1;
  int beat_global = 0;
  logic ready_after_run;

  always @(negedge clk) begin
    if (out_wr) begin
      wr_addr_q.push_back(out_addr);
      wr_data_q.push_back(out_data);
      wr_ready_q.push_back(dma_ready);
    end
    if (m_axi_arvalid) arvalid_cycles++;
    if (!dma_ready) notready_cycles++;
  end

  // AXI read slave: handshakes decided from negedge samples, new drive values applied just after posedge
  initial begin : slave
    logic        s_rst, s_ar, s_r;
    logic [31:0] s_araddr, sl_addr;
    logic [7:0]  s_arlen;
    int          sl_left;
    bit          sl_active;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rid = 1'b0;
    sl_active = 1'b0; sl_addr = '0; sl_left = 0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_ar = m_axi_arvalid && m_axi_arready;
      s_r  = m_axi_rvalid && m_axi_rready;
      s_araddr = m_axi_araddr;
      s_arlen  = m_axi_arlen;
      @(posedge clk);
      #1;
      if (s_rst) begin
        sl_active = 1'b0;
        m_axi_rvalid = 1'b0;
      end else begin
        if (s_ar) begin
          ar_addr_q.push_back(s_araddr);
          ar_len_q.push_back(s_arlen);
          sl_active = 1'b1;
          sl_addr = s_araddr;
          sl_left = int'(s_arlen) + 1;
        end
        if (s_r) begin
          sl_addr += 32'd4;
          sl_left--;
          beat_global++;
          if (sl_left == 0) sl_active = 1'b0;
        end
      end
      m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!(m_axi_rvalid && !s_r && !s_rst))
        m_axi_rvalid = sl_active && (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
      m_axi_rdata = {mem_byte(sl_addr + 32'd3), mem_byte(sl_addr + 32'd2),
                     mem_byte(sl_addr + 32'd1), mem_byte(sl_addr)};
      m_axi_rlast = (sl_left == 1);
      m_axi_rresp = (beat_global == err_beat) ? 2'b10 : 2'b00;
    end
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_ready_q.delete();
    arvalid_cycles = 0;
    notready_cycles = 0;
  endtask

  // Frame model: byte copy plus burst split (remaining words, burst cap, 4 KB page)
  task automatic model_xfer(input logic [31:0] a, input logic [10:0] s, input logic [10:0] e);
    int n, rem, words, bw, gap;
    logic [31:0] ad;
    exp_wa.delete(); exp_wd.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    n = (e > s) ? int'(e) - int'(s) : 0;
    for (int i = 0; i < n; i++) begin
      exp_wa.push_back(11'(int'(s) + i));
      exp_wd.push_back(mem_byte(a + 32'(i)));
    end
    ad = a;
    rem = n;
    while (rem > 0) begin
      words = (rem + 3) / 4;
      gap = (4096 - int'(ad % 32'd4096)) / 4;
      bw = words;
      if (bw > BMAX) bw = BMAX;
      if (bw > gap) bw = gap;
      exp_ar_addr.push_back(ad);
      exp_ar_len.push_back(8'(bw - 1));
      ad += 32'(bw * 4);
      rem -= (rem < bw * 4) ? rem : bw * 4;
    end
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [10:0] s, input logic [10:0] e);
    @(posedge clk); #1;
    dma_addr = a; dma_start_index = s; dma_end_index = e; dma_run = 1'b1;
    @(posedge clk); #1;
    dma_run = 1'b0;
    @(negedge clk);
    ready_after_run = dma_ready;
  endtask

  task automatic wait_done(output bit to);
    int c;
    c = 0;
    to = 1'b1;
    while (c < 5000) begin
      @(negedge clk);
      if (dma_ready) begin
        to = 1'b0;
        break;
      end
      c++;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_state();
    rst = 1'b1; dma_run = 1'b0; dma_addr = '0; dma_start_index = '0; dma_end_index = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (dma_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", dma_ready); end
    n_checks++; if (dma_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", dma_error); end
    n_checks++; if (out_wr !== 1'b0) begin n_fail++; $display("FAIL reset_out_wr: got %b want 0", out_wr); end
    n_checks++; if (out_addr !== 11'd0 || out_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_out: got addr %0d data %0d want 0 0", out_addr, out_data);
    end
    n_checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      n_fail++; $display("FAIL reset_axi: got arvalid %b rready %b want 0 0", m_axi_arvalid, m_axi_rready);
    end
    n_checks++; if (m_axi_arsize !== 3'b010 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'b0011 || m_axi_arid !== 1'b0) begin
      n_fail++; $display("FAIL ar_consts: got size %b burst %b cache %b id %b", m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("test_reset_state done");
  endtask

  task automatic test_transfer(input string name, input logic [31:0] a, input logic [10:0] s,
                               input logic [10:0] e, input bit stall, input bit mid_run,
                               input int err_b, input logic [7:0] p);
    bit to;
    int ones, nbeats;
    bit exp_err;
    pat = p;
    stall_en = stall;
    err_beat = err_b;
    beat_global = 0;
    clear_logs();
    model_xfer(a, s, e);
    start_xfer(a, s, e);
    if (mid_run) begin
      repeat (8) @(posedge clk);
      #1;
      dma_addr = a + 32'h100; dma_start_index = 11'd0; dma_end_index = 11'd100; dma_run = 1'b1;
      @(posedge clk); #1;
      dma_run = 1'b0;
    end
    wait_done(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL %s timeout: dma_ready never returned", name); end
    n_checks++; if (ready_after_run !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_drop: got %b want 0", name, ready_after_run);
    end
    n_checks++; if (wr_addr_q.size() != exp_wa.size()) begin
      n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wr_addr_q.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
      n_checks++;
      if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr %0d data %h want addr %0d data %h",
                 name, i, wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
      end
    end
    n_checks++; if (ar_addr_q.size() != exp_ar_addr.size()) begin
      n_fail++; $display("FAIL %s burst_count: got %0d want %0d", name, ar_addr_q.size(), exp_ar_addr.size());
    end
    nbeats = 0;
    for (int i = 0; i < exp_ar_addr.size(); i++) begin
      nbeats += int'(exp_ar_len[i]) + 1;
      if (i < ar_addr_q.size()) begin
        n_checks++;
        if (ar_addr_q[i] !== exp_ar_addr[i] || ar_len_q[i] !== exp_ar_len[i]) begin
          n_fail++;
          $display("FAIL %s burst[%0d]: got addr %h len %0d want addr %h len %0d",
                   name, i, ar_addr_q[i], ar_len_q[i], exp_ar_addr[i], exp_ar_len[i]);
        end
      end
    end
    ones = 0;
    foreach (wr_ready_q[i]) if (wr_ready_q[i]) ones++;
    n_checks++;
    if (ones != 1 || wr_ready_q.size() == 0 || wr_ready_q[wr_ready_q.size()-1] !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_rise: got %0d writes with ready high, want exactly the final one", name, ones);
    end
    exp_err = ERR_EN && (err_b >= 0) && (err_b < nbeats);
    n_checks++; if (dma_error !== exp_err) begin
      n_fail++; $display("FAIL %s error_flag: got %b want %b", name, dma_error, exp_err);
    end
    $display("test_transfer %s: addr %h start %0d end %0d, %0d writes, %0d bursts", name, a, s, e,
             wr_addr_q.size(), ar_addr_q.size());
  endtask

  task automatic test_empty();
    logic [10:0] s_tab[2];
    logic [10:0] e_tab[2];
    s_tab[0] = 11'd20; e_tab[0] = 11'd20;
    s_tab[1] = 11'd30; e_tab[1] = 11'd10;
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      start_xfer(32'h3000, s_tab[k], e_tab[k]);
      repeat (20) @(negedge clk);
      n_checks++; if (ready_after_run !== 1'b1 || notready_cycles != 0) begin
        n_fail++; $display("FAIL empty_ready[%0d]: got %0d not-ready cycles want 0", k, notready_cycles);
      end
      n_checks++; if (arvalid_cycles != 0 || wr_addr_q.size() != 0) begin
        n_fail++; $display("FAIL empty_activity[%0d]: got %0d arvalid cycles %0d writes want 0 0",
                           k, arvalid_cycles, wr_addr_q.size());
      end
      $display("test_empty case %0d: start %0d end %0d", k, s_tab[k], e_tab[k]);
    end
  endtask

  task automatic test_error();
    bit to;
    pat = 8'h5A;
    stall_en = 1'b0;
    err_beat = 2;
    beat_global = 0;
    clear_logs();
    start_xfer(32'h4000, 11'd0, 11'd40);
    wait_done(to);
    n_checks++; if (to || wr_addr_q.size() != 40) begin
      n_fail++; $display("FAIL err_complete: got %0d writes timeout %b want 40 0", wr_addr_q.size(), to);
    end
    n_checks++; if (dma_error !== ERR_EN) begin
      n_fail++; $display("FAIL err_set: got %b want %b", dma_error, ERR_EN);
    end
    err_beat = -1;
    beat_global = 0;
    clear_logs();
    start_xfer(32'h4100, 11'd0, 11'd8);
    n_checks++; if (dma_error !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", dma_error);
    end
    wait_done(to);
    n_checks++; if (to || wr_addr_q.size() != 8) begin
      n_fail++; $display("FAIL err_second: got %0d writes timeout %b want 8 0", wr_addr_q.size(), to);
    end
    $display("test_error: error flag %b after faulty beat", ERR_EN);
  endtask

  task automatic test_reset_mid();
    int c;
    pat = 8'h33;
    stall_en = 1'b0;
    err_beat = -1;
    beat_global = 0;
    clear_logs();
    start_xfer(32'h5000, 11'd0, 11'd60);
    c = 0;
    while (wr_addr_q.size() < 5 && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (wr_addr_q.size() < 5) begin
      n_fail++; $display("FAIL rst_mid_progress: got %0d writes want at least 5", wr_addr_q.size());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || dma_ready !== 1'b1 || out_wr !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got arvalid %b rready %b ready %b out_wr %b want 0 0 1 0",
                         m_axi_arvalid, m_axi_rready, dma_ready, out_wr);
    end
    clear_logs();
    repeat (10) @(negedge clk);
    n_checks++; if (arvalid_cycles != 0 || wr_addr_q.size() != 0 || notready_cycles != 0) begin
      n_fail++; $display("FAIL rst_mid_idle: got %0d arvalid cycles %0d writes after reset want 0 0",
                         arvalid_cycles, wr_addr_q.size());
    end
    $display("test_reset_mid: reset applied after %0d cycles of transfer", c);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [10:0] s, e;
    int n;
    bit mid;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) a = ($urandom & 32'hFFFF_F000) + 32'd4096 - 32'(4 * $urandom_range(1, 24));
      else            a = $urandom & 32'hFFFF_FFFC;
      n = $urandom_range(1, 300);
      s = 11'($urandom_range(0, 2047 - n));
      e = 11'(int'(s) + n);
      mid = (n >= 40) && ($urandom_range(0, 1) == 1);
      test_transfer("random", a, s, e, 1'($urandom_range(0, 1)), mid, -1, 8'($urandom));
    end
  endtask

  initial begin
    test_reset_state();
    test_transfer("basic", 32'h0000_1000, 11'd0, 11'd60, 1'b0, 1'b0, -1, 8'h00);
    test_transfer("tail", 32'h0000_2000, 11'd10, 11'd73, 1'b0, 1'b0, -1, 8'hA5);
    test_transfer("page_4k", 32'h0000_0FF8, 11'd100, 11'd132, 1'b0, 1'b0, -1, 8'h17);
    test_transfer("stall_midrun", 32'h0000_6010, 11'd200, 11'd290, 1'b1, 1'b1, -1, 8'hC3);
    test_random();
    test_empty();
    test_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
